// File: rtl/washer_phase_timer.sv
// Phase timer for the washer controller: a prescaled seconds counter with one
// registered, monotonic "phase done" flag per phase threshold.
module washer_phase_timer #(
   parameter int TICK_DIV = 50_000_000,
   parameter int PW       = 26,
   parameter int CNT_W    = 8,
   parameter int FILL_T   = 30,
   parameter int WASH_T   = 120,
   parameter int DRAIN_T  = 30,
   parameter int RINSE_T  = 60,
   parameter int SPIN_T   = 90
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             R,
   input  logic             pause,
   output logic             Tf,
   output logic             Tw,
   output logic             Td,
   output logic             Tr,
   output logic             Ts,
   output logic             tick,
   output logic [CNT_W-1:0] secs
);

   localparam int NPH = 5;
   localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] SECS_MAX  = '1;
   // Flag index order: 0 fill, 1 wash, 2 drain, 3 rinse, 4 spin.
   localparam logic [NPH-1:0][CNT_W-1:0] THRESH = {
      CNT_W'(SPIN_T), CNT_W'(RINSE_T), CNT_W'(DRAIN_T), CNT_W'(WASH_T), CNT_W'(FILL_T)
   };

   logic [PW-1:0]    presc_reg, presc_next;
   logic [CNT_W-1:0] secs_reg, secs_next, secs_count;
   logic [NPH-1:0]   flag_reg, flag_next, flag_count;
   logic             tick_reg, tick_next;
   logic             wrap;

   assign wrap       = (presc_reg == PRESC_MAX);
   assign secs_count = (wrap && (secs_reg != SECS_MAX)) ? secs_reg + 1'b1 : secs_reg;

   // Flags compare against the post-increment value so they rise on the same
   // edge the counter reaches the threshold.
   generate
      for (genvar gi = 0; gi < NPH; gi++) begin : g_flag
         assign flag_count[gi] = (secs_count >= THRESH[gi]);
      end
   endgenerate

   always_comb begin
      presc_next = presc_reg;
      secs_next  = secs_reg;
      flag_next  = flag_reg;
      tick_next  = 1'b0;
      if (R) begin
         presc_next = '0;
         secs_next  = '0;
         flag_next  = '0;
      end else if (!pause) begin
         presc_next = wrap ? '0 : presc_reg + 1'b1;
         secs_next  = secs_count;
         flag_next  = flag_count;
         tick_next  = wrap;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_reg <= '0;
         secs_reg  <= '0;
         flag_reg  <= '0;
         tick_reg  <= 1'b0;
      end else begin
         presc_reg <= presc_next;
         secs_reg  <= secs_next;
         flag_reg  <= flag_next;
         tick_reg  <= tick_next;
      end
   end

   assign Tf   = flag_reg[0];
   assign Tw   = flag_reg[1];
   assign Td   = flag_reg[2];
   assign Tr   = flag_reg[3];
   assign Ts   = flag_reg[4];
   assign tick = tick_reg;
   assign secs = secs_reg;

endmodule

// File: tb/tb_washer_phase_timer.sv
// Bench for washer_phase_timer: hand-computed vector table, an async-probe
// sequence, and randomized traffic checked against an elapsed-cycle model.
module tb_washer_phase_timer;

   localparam int TICK_DIV = 4;
   localparam int PW       = 2;
   localparam int CNT_W    = 4;
   localparam int FILL_T   = 3;
   localparam int WASH_T   = 5;
   localparam int DRAIN_T  = 2;
   localparam int RINSE_T  = 4;
   localparam int SPIN_T   = 6;
   localparam int SMAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             R = 1'b0;
   logic             pause = 1'b0;
   logic             Tf, Tw, Td, Tr, Ts, tick;
   logic [CNT_W-1:0] secs;

   washer_phase_timer #(
      .TICK_DIV(TICK_DIV), .PW(PW), .CNT_W(CNT_W),
      .FILL_T(FILL_T), .WASH_T(WASH_T), .DRAIN_T(DRAIN_T),
      .RINSE_T(RINSE_T), .SPIN_T(SPIN_T)
   ) dut (
      .clk(clk), .reset(reset), .R(R), .pause(pause),
      .Tf(Tf), .Tw(Tw), .Td(Td), .Tr(Tr), .Ts(Ts),
      .tick(tick), .secs(secs)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: counted (unpaused) cycles since the last clear; everything else
   // is derived arithmetically from that count.
   int n_model = 0;
   bit tick_model = 1'b0;
   int thr[5] = '{FILL_T, WASH_T, DRAIN_T, RINSE_T, SPIN_T};

   function automatic int model_secs();
      return (n_model / TICK_DIV > SMAX) ? SMAX : n_model / TICK_DIV;
   endfunction

   // Bit order {Tf, Tw, Td, Tr, Ts}.
   function automatic int model_flags();
      int f = 0;
      for (int i = 0; i < 5; i++)
         if (model_secs() >= thr[i]) f |= (1 << (4 - i));
      return f;
   endfunction

   function automatic int dut_flags();
      return int'({Tf, Tw, Td, Tr, Ts});
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit rst, input bit r, input bit p);
      reset = rst;
      R     = r;
      pause = p;
      @(posedge clk);
      if (rst || r) begin
         n_model    = 0;
         tick_model = 1'b0;
      end else if (p) begin
         tick_model = 1'b0;
      end else begin
         n_model++;
         tick_model = (n_model % TICK_DIV == 0);
      end
      #1;
      check("model_secs", int'(secs), model_secs());
      check("model_flags", dut_flags(), model_flags());
      check("model_tick", int'(tick), int'(tick_model));
   endtask

   typedef struct {
      bit       rst;
      bit       r;
      bit       p;
      int       n;
      bit       probe;
      int       e_secs;
      bit [4:0] e_flags;
      bit       e_tick;
      string    name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      // rst r p  n  probe secs flags     tick
      vecs.push_back('{1, 0, 0,  2, 0, 0, 5'b00000, 0, "reset"});
      vecs.push_back('{0, 1, 0,  1, 0, 0, 5'b00000, 0, "restart"});
      vecs.push_back('{0, 0, 0,  3, 0, 0, 5'b00000, 0, "edge3"});
      vecs.push_back('{0, 0, 0,  1, 0, 1, 5'b00000, 1, "edge4"});
      vecs.push_back('{0, 0, 0,  4, 0, 2, 5'b00100, 1, "edge8_Td"});
      vecs.push_back('{0, 0, 0,  4, 0, 3, 5'b10100, 1, "edge12_Tf"});
      vecs.push_back('{0, 0, 0,  4, 0, 4, 5'b10110, 1, "edge16_Tr"});
      vecs.push_back('{0, 0, 0,  4, 0, 5, 5'b11110, 1, "edge20_Tw"});
      vecs.push_back('{0, 0, 0,  4, 0, 6, 5'b11111, 1, "edge24_Ts"});
      vecs.push_back('{0, 0, 0,  1, 0, 6, 5'b11111, 0, "edge25"});
      vecs.push_back('{0, 1, 0,  1, 0, 0, 5'b00000, 0, "R_clear"});
      vecs.push_back('{0, 0, 0,  8, 0, 2, 5'b00100, 1, "recount_8"});
      vecs.push_back('{0, 0, 1, 10, 0, 2, 5'b00100, 0, "pause10"});
      vecs.push_back('{0, 0, 0,  3, 0, 2, 5'b00100, 0, "release3"});
      vecs.push_back('{0, 0, 0,  1, 0, 3, 5'b10100, 1, "release4_Tf"});
      vecs.push_back('{0, 1, 1,  1, 0, 0, 5'b00000, 0, "R_and_pause"});
      vecs.push_back('{0, 0, 0, 80, 0, SMAX, 5'b11111, 1, "saturate80"});
      vecs.push_back('{0, 0, 0,  1, 0, SMAX, 5'b11111, 0, "sat_plus1"});
      vecs.push_back('{0, 0, 0,  3, 0, SMAX, 5'b11111, 1, "sat_tick"});
      vecs.push_back('{0, 1, 0,  1, 0, 0, 5'b00000, 0, "R_again"});
      vecs.push_back('{0, 0, 0, 18, 0, 4, 5'b10110, 0, "secs4_presc2"});
      vecs.push_back('{1, 0, 0,  1, 1, 0, 5'b00000, 0, "reset_mid"});
      vecs.push_back('{0, 0, 0,  3, 0, 0, 5'b00000, 0, "post_reset3"});
      vecs.push_back('{0, 0, 0,  1, 0, 1, 5'b00000, 1, "post_reset4"});

      foreach (vecs[k]) begin
         if (vecs[k].probe) begin
            // Reset raised between edges must not disturb outputs until the edge.
            reset = 1'b1;
            #3;
            check("probe_secs", int'(secs), model_secs());
            check("probe_flags", dut_flags(), model_flags());
         end
         repeat (vecs[k].n) cyc(vecs[k].rst, vecs[k].r, vecs[k].p);
         check({vecs[k].name, "_secs"}, int'(secs), vecs[k].e_secs);
         check({vecs[k].name, "_flags"}, dut_flags(), int'(vecs[k].e_flags));
         check({vecs[k].name, "_tick"}, int'(tick), int'(vecs[k].e_tick));
         $display("vec %0d %s: secs=%0d flags=%05b tick=%0b", k, vecs[k].name,
                  secs, dut_flags(), tick);
      end

      // Randomized traffic: occasional reset/restart, frequent pauses.
      for (int i = 0; i < 2000; i++) begin
         bit rr, r, p;
         rr = ($urandom_range(0, 199) == 0);
         r  = ($urandom_range(0, 59) == 0);
         p  = ($urandom_range(0, 3) == 0);
         cyc(rr, r, p);
      end
      $display("random phase done: 2000 cycles, secs=%0d", secs);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
